relu16_bwd: RTL and testbench

//   Backward-pass companion to the relu16 forward activation. During the

---
 rtl/relu16_bwd.sv | 153 +++++++++++++++
 tb/tb_relu16_bwd.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/relu16_bwd.sv
// relu16_bwd: forward ReLU stage that records one mask bit per element in a
// small FIFO, then replays those masks in order to gate backward gradients.
module relu16_bwd #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          fwd_en,
   input  logic signed [DATA_WIDTH-1:0]  fwd_din,
   output logic signed [DATA_WIDTH-1:0]  fwd_dout,
   input  logic                          bwd_valid,
   output logic                          bwd_ready,
   input  logic signed [DATA_WIDTH-1:0]  bwd_grad,
   output logic                          out_valid,
   output logic signed [DATA_WIDTH-1:0]  out_grad,
   output logic [$clog2(DEPTH):0]        mask_count,
   output logic                          full,
   output logic                          empty,
   output logic                          ovf_err,
   output logic                          unf_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Mask storage and FIFO bookkeeping
   logic [DEPTH-1:0]              mask_mem_q, mask_mem_d;
   logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]                 count_q, count_d;

   // Datapath and status registers
   logic signed [DATA_WIDTH-1:0]  fwd_dout_q, fwd_dout_d;
   logic signed [DATA_WIDTH-1:0]  out_grad_q, out_grad_d;
   logic                          out_valid_q, out_valid_d;
   logic                          ovf_err_q, ovf_err_d;
   logic                          unf_err_q, unf_err_d;

   // Handshake decode
   logic                          fwd_mask;
   logic                          rd_mask;
   logic                          pop_raw;
   logic                          push;
   logic                          pop;
   logic                          is_full;
   logic                          is_empty;

   // Status flags, handshake and push/pop qualification; clr suppresses both
   // FIFO operations, and a pop frees the slot a same-cycle push needs at full.
   always_comb begin
      is_empty = (count_q == '0);
      is_full  = (count_q == CW'(DEPTH));
      fwd_mask = !fwd_din[DATA_WIDTH-1] && (fwd_din != '0);
      rd_mask  = mask_mem_q[rd_ptr_q];
      pop_raw  = bwd_valid && !is_empty;
      push     = fwd_en && (!is_full || pop_raw) && !clr;
      pop      = pop_raw && !clr;
   end

   // Next-state for FIFO memory, pointers and occupancy count
   always_comb begin
      mask_mem_d = mask_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mask_mem_d[wr_ptr_q] = fwd_mask;
            wr_ptr_d             = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Next-state for forward output, gated gradient and sticky error flags
   always_comb begin
      fwd_dout_d  = fwd_dout_q;
      out_grad_d  = out_grad_q;
      out_valid_d = 1'b0;
      ovf_err_d   = ovf_err_q;
      unf_err_d   = unf_err_q;
      if (fwd_en) begin
         fwd_dout_d = fwd_mask ? fwd_din : '0;
      end
      if (pop) begin
         out_grad_d  = rd_mask ? bwd_grad : '0;
         out_valid_d = 1'b1;
      end
      if (clr) begin
         ovf_err_d = 1'b0;
         unf_err_d = 1'b0;
      end else begin
         if (fwd_en && is_full && !pop_raw) begin
            ovf_err_d = 1'b1;
         end
         if (bwd_valid && is_empty) begin
            unf_err_d = 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_mem_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         fwd_dout_q  <= '0;
         out_grad_q  <= '0;
         out_valid_q <= 1'b0;
         ovf_err_q   <= 1'b0;
         unf_err_q   <= 1'b0;
      end else begin
         mask_mem_q  <= mask_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         fwd_dout_q  <= fwd_dout_d;
         out_grad_q  <= out_grad_d;
         out_valid_q <= out_valid_d;
         ovf_err_q   <= ovf_err_d;
         unf_err_q   <= unf_err_d;
      end
   end

   // Output wiring
   always_comb begin
      fwd_dout   = fwd_dout_q;
      out_grad   = out_grad_q;
      out_valid  = out_valid_q;
      mask_count = count_q;
      full       = is_full;
      empty      = is_empty;
      bwd_ready  = !is_empty;
      ovf_err    = ovf_err_q;
      unf_err    = unf_err_q;
   end

endmodule

// File: tb/tb_relu16_bwd.sv
// tb_relu16_bwd: directed vectors with hand-computed expectations for the
// ReLU forward/backward mask FIFO.
module tb_relu16_bwd;

   localparam int DW    = 16;
   localparam int DEPTH = 64;

   logic                  clk;
   logic                  rst_n;
   logic                  clr;
   logic                  fwd_en;
   logic signed [DW-1:0]  fwd_din;
   logic signed [DW-1:0]  fwd_dout;
   logic                  bwd_valid;
   logic                  bwd_ready;
   logic signed [DW-1:0]  bwd_grad;
   logic                  out_valid;
   logic signed [DW-1:0]  out_grad;
   logic [6:0]            mask_count;
   logic                  full;
   logic                  empty;
   logic                  ovf_err;
   logic                  unf_err;

   int testsRun  = 0;
   int failCount = 0;

   relu16_bwd #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .fwd_en     (fwd_en),
      .fwd_din    (fwd_din),
      .fwd_dout   (fwd_dout),
      .bwd_valid  (bwd_valid),
      .bwd_ready  (bwd_ready),
      .bwd_grad   (bwd_grad),
      .out_valid  (out_valid),
      .out_grad   (out_grad),
      .mask_count (mask_count),
      .full       (full),
      .empty      (empty),
      .ovf_err    (ovf_err),
      .unf_err    (unf_err)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value and log mismatches
   task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, clock it in, and settle 1 ns past the edge
   task automatic applyStimulus(input logic c, input logic fe,
                                input logic signed [DW-1:0] din,
                                input logic bv, input logic signed [DW-1:0] g);
      clr       = c;
      fwd_en    = fe;
      fwd_din   = din;
      bwd_valid = bv;
      bwd_grad  = g;
      @(posedge clk);
      #1;
   endtask

   // Return all inputs to idle for one cycle
   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
   endtask

   // Directed scenario sequence
   initial begin
      rst_n     = 1'b0;
      clr       = 1'b0;
      fwd_en    = 1'b0;
      fwd_din   = '0;
      bwd_valid = 1'b0;
      bwd_grad  = '0;
      #12;
      checkOutput("rst_fwd_dout",  fwd_dout, 0);
      checkOutput("rst_out_grad",  out_grad, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_count",     mask_count, 0);
      checkOutput("rst_empty",     empty, 1);
      checkOutput("rst_full",      full, 0);
      checkOutput("rst_ovf",       ovf_err, 0);
      checkOutput("rst_unf",       unf_err, 0);
      checkOutput("rst_ready",     bwd_ready, 0);
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Forward pass: -5, 0, 123
      applyStimulus(1'b0, 1'b1, -16'sd5, 1'b0, '0);
      checkOutput("fwd_neg", fwd_dout, 0);
      checkOutput("fwd_cnt1", mask_count, 1);
      applyStimulus(1'b0, 1'b1, 16'sd0, 1'b0, '0);
      checkOutput("fwd_zero", fwd_dout, 0);
      applyStimulus(1'b0, 1'b1, 16'sd123, 1'b0, '0);
      checkOutput("fwd_pos", fwd_dout, 123);
      checkOutput("fwd_cnt3", mask_count, 3);
      idleCycle();
      checkOutput("fwd_hold", fwd_dout, 123);
      checkOutput("ready_nonempty", bwd_ready, 1);

      // Backward pass: grads 7, 8, 9 gated by masks 0, 0, 1
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'sd7);
      checkOutput("bwd_g0", out_grad, 0);
      checkOutput("bwd_v0", out_valid, 1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'sd8);
      checkOutput("bwd_g1", out_grad, 0);
      checkOutput("bwd_v1", out_valid, 1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'sd9);
      checkOutput("bwd_g2", out_grad, 9);
      checkOutput("bwd_v2", out_valid, 1);
      checkOutput("bwd_empty", empty, 1);
      idleCycle();
      checkOutput("bwd_vdrop", out_valid, 0);
      checkOutput("bwd_ghold", out_grad, 9);
      checkOutput("bwd_unf_clean", unf_err, 0);

      // Fill to DEPTH (pointers start mid-buffer, so they wrap), then overflow
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 16'sd1, 1'b0, '0);
      checkOutput("fill_count", mask_count, DEPTH);
      checkOutput("fill_full", full, 1);
      checkOutput("fill_ovf0", ovf_err, 0);
      applyStimulus(1'b0, 1'b1, 16'sd1, 1'b0, '0);
      checkOutput("ovf_set", ovf_err, 1);
      checkOutput("ovf_count", mask_count, DEPTH);
      checkOutput("ovf_dout", fwd_dout, 1);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, '0, 1'b1, -16'sd3);
         checkOutput("drain_grad", out_grad, -3);
         checkOutput("drain_valid", out_valid, 1);
      end
      checkOutput("drain_empty", empty, 1);
      checkOutput("drain_count", mask_count, 0);

      // Clear, refill, then push and pop together at full
      applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
      checkOutput("clr_ovf", ovf_err, 0);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 16'sd1, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 16'sd2, 1'b1, 16'sd4);
      checkOutput("fp_grad", out_grad, 4);
      checkOutput("fp_valid", out_valid, 1);
      checkOutput("fp_count", mask_count, DEPTH);
      checkOutput("fp_ovf", ovf_err, 0);
      checkOutput("fp_dout", fwd_dout, 2);

      // clr beats a simultaneous push/pop; fwd_dout still follows fwd_en
      applyStimulus(1'b1, 1'b1, 16'sd55, 1'b1, 16'sd6);
      checkOutput("clrw_count", mask_count, 0);
      checkOutput("clrw_valid", out_valid, 0);
      checkOutput("clrw_dout", fwd_dout, 55);
      checkOutput("clrw_grad_hold", out_grad, 4);

      // Underflow, then clear
      clr = 1'b0; fwd_en = 1'b0; bwd_valid = 1'b1; bwd_grad = 16'sd11;
      #1;
      checkOutput("unf_ready", bwd_ready, 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'sd11);
      checkOutput("unf_valid", out_valid, 0);
      checkOutput("unf_set", unf_err, 1);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
      checkOutput("unf_clr", unf_err, 0);

      // Empty plus push plus bwd_valid: push only, no bypass
      applyStimulus(1'b0, 1'b1, 16'sd20, 1'b1, 16'sd13);
      checkOutput("nobyp_valid", out_valid, 0);
      checkOutput("nobyp_count", mask_count, 1);
      checkOutput("nobyp_unf", unf_err, 1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'sd13);
      checkOutput("nobyp_grad", out_grad, 13);
      checkOutput("nobyp_valid2", out_valid, 1);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);

      // Asynchronous reset mid-stream
      applyStimulus(1'b0, 1'b1, 16'sd5, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 16'sd6, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 16'sd7, 1'b0, '0);
      checkOutput("pre_rst_count", mask_count, 3);
      fwd_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mrst_dout", fwd_dout, 0);
      checkOutput("mrst_empty", empty, 1);
      checkOutput("mrst_count", mask_count, 0);
      checkOutput("mrst_grad", out_grad, 0);
      #1 rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'sd9);
      checkOutput("post_rst_unf", unf_err, 1);
      checkOutput("post_rst_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
